// File: rtl/cache_bus1_responder_pkg.sv
// Shared definitions for the cache side of CPU<->cache bus 1: widths, C1 command codes,
// responder state encoding and small decode/address helpers.
package cache_bus1_responder_pkg;

    localparam int ADDR1_BUS_SIZE    = 15;
    localparam int DATA_BUS_SIZE     = 16;
    localparam int CTR1_BUS_SIZE     = 3;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int CACHE_ADDR_SIZE   = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

    typedef logic [CTR1_BUS_SIZE-1:0] c1_code_t;

    // WRITE32 and RESPONSE share a code; direction tells them apart.
    localparam c1_code_t C1_NOP             = 3'd0;
    localparam c1_code_t C1_READ8           = 3'd1;
    localparam c1_code_t C1_READ16          = 3'd2;
    localparam c1_code_t C1_READ32          = 3'd3;
    localparam c1_code_t C1_INVALIDATE_LINE = 3'd4;
    localparam c1_code_t C1_WRITE8          = 3'd5;
    localparam c1_code_t C1_WRITE16         = 3'd6;
    localparam c1_code_t C1_WRITE32         = 3'd7;
    localparam c1_code_t C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR2 = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP1 = 3'd4,
        RESP2 = 3'd5
    } bus1_state_t;

    function automatic logic is_request(input c1_code_t code);
        case (code)
            C1_READ8, C1_READ16, C1_READ32, C1_INVALIDATE_LINE,
            C1_WRITE8, C1_WRITE16, C1_WRITE32: is_request = 1'b1;
            default:                           is_request = 1'b0;
        endcase
    endfunction

    function automatic logic is_read(input c1_code_t code);
        is_read = (code == C1_READ8) || (code == C1_READ16) || (code == C1_READ32);
    endfunction

    function automatic logic [CACHE_ADDR_SIZE-1:0] build_req_addr(
        input logic [ADDR1_BUS_SIZE-1:0]    tag_set,
        input logic [CACHE_OFFSET_SIZE-1:0] offset
    );
        build_req_addr = {tag_set, offset};
    endfunction

endpackage

// File: rtl/cache_bus1_responder.sv
// Cache-side responder on bus 1: samples two-cycle CPU commands on the falling edge,
// hands one request to the cache core, then owns C1/D1 to return the response.
module cache_bus1_responder
    import cache_bus1_responder_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RESET,
    inout  wire  [ADDR1_BUS_SIZE-1:0]    A1_WIRE,
    inout  wire  [DATA_BUS_SIZE-1:0]     D1_WIRE,
    inout  wire  [CTR1_BUS_SIZE-1:0]     C1_WIRE,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [CTR1_BUS_SIZE-1:0]     req_cmd,
    output logic [CACHE_ADDR_SIZE-1:0]   req_addr,
    output logic [2*DATA_BUS_SIZE-1:0]   req_wdata,
    input  logic                         rsp_valid,
    input  logic [2*DATA_BUS_SIZE-1:0]   rsp_rdata,
    output logic                         proto_err
);

    bus1_state_t                   state_q, state_d;
    c1_code_t                      c1_s_q;
    logic [ADDR1_BUS_SIZE-1:0]     a1_s_q;
    logic [DATA_BUS_SIZE-1:0]      d1_s_q;
    c1_code_t                      cmd_q;
    logic [ADDR1_BUS_SIZE-1:0]     tag_set_q;
    logic [CACHE_OFFSET_SIZE-1:0]  offset_q;
    logic [DATA_BUS_SIZE-1:0]      wlo_q, whi_q;
    logic [2*DATA_BUS_SIZE-1:0]    rdata_q;
    logic                          proto_err_q;

    logic                          c1_oe, d1_oe;
    c1_code_t                      c1_drv;
    logic [DATA_BUS_SIZE-1:0]      d1_drv;
    logic                          cmd_seen, contention, rsp_stray;

    // CPU drives on the rising edge, so the bus is captured half a cycle later.
    // NOTE: sequential state uses <= so every flop sees the pre-edge values of the others.
    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            c1_s_q <= C1_NOP;
            a1_s_q <= '0;
            d1_s_q <= '0;
        end else begin
            c1_s_q <= C1_WIRE;
            a1_s_q <= A1_WIRE;
            d1_s_q <= D1_WIRE;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cmd_seen = is_request(c1_s_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_seen) state_d = ADDR2;
            ADDR2:   state_d = ISSUE;
            ISSUE:   if (req_ready) state_d = WAIT;
            WAIT:    if (rsp_valid) state_d = RESP1;
            RESP1:   state_d = (cmd_q == C1_READ32) ? RESP2 : IDLE;
            RESP2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no branch can infer a latch.
    always_comb begin
        c1_oe     = 1'b0;
        c1_drv    = C1_NOP;
        d1_oe     = 1'b0;
        d1_drv    = '0;
        req_valid = 1'b0;
        case (state_q)
            ISSUE: begin
                c1_oe     = 1'b1;
                req_valid = 1'b1;
            end
            WAIT: begin
                c1_oe = 1'b1;
            end
            RESP1: begin
                c1_oe  = 1'b1;
                c1_drv = C1_RESPONSE;
                d1_oe  = is_read(cmd_q);
                d1_drv = (cmd_q == C1_READ8) ? {{(DATA_BUS_SIZE-8){1'b0}}, rdata_q[7:0]}
                                             : rdata_q[DATA_BUS_SIZE-1:0];
            end
            RESP2: begin
                c1_oe  = 1'b1;
                c1_drv = C1_RESPONSE;
                d1_oe  = 1'b1;
                d1_drv = rdata_q[2*DATA_BUS_SIZE-1:DATA_BUS_SIZE];
            end
            default: ;
        endcase
    end

    // The C1 sample was taken while state_q already held its current value.
    assign contention = c1_oe && (c1_s_q != c1_drv);
    assign rsp_stray  = rsp_valid && (state_q != WAIT) && !((state_q == ISSUE) && req_ready);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cmd_q       <= C1_NOP;
            tag_set_q   <= '0;
            offset_q    <= '0;
            wlo_q       <= '0;
            whi_q       <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= rsp_stray | contention;
            case (state_q)
                IDLE: begin
                    if (cmd_seen) begin
                        cmd_q     <= c1_s_q;
                        tag_set_q <= a1_s_q;
                        offset_q  <= '0;
                        whi_q     <= '0;
                        case (c1_s_q)
                            C1_WRITE8:             wlo_q <= {{(DATA_BUS_SIZE-8){1'b0}}, d1_s_q[7:0]};
                            C1_WRITE16, C1_WRITE32: wlo_q <= d1_s_q;
                            default:               wlo_q <= '0;
                        endcase
                    end
                end
                ADDR2: begin
                    offset_q <= a1_s_q[CACHE_OFFSET_SIZE-1:0];
                    whi_q    <= (cmd_q == C1_WRITE32) ? d1_s_q : '0;
                end
                WAIT: begin
                    if (rsp_valid) rdata_q <= rsp_rdata;
                end
                default: ;
            endcase
        end
    end

    assign req_cmd   = cmd_q;
    assign req_addr  = build_req_addr(tag_set_q, offset_q);
    assign req_wdata = {whi_q, wlo_q};
    assign proto_err = proto_err_q;

    assign A1_WIRE = 'z;
    assign C1_WIRE = c1_oe ? c1_drv : 'z;
    assign D1_WIRE = d1_oe ? d1_drv : 'z;

endmodule
